hazard_ctrl: RTL

// Pipeline hazard controller; generates the flush/stall controls consumed by the IF/ID and ID/EX

---
 rtl/hazard_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard controller. Produces the stall/flush controls for the PC,
// the IF/ID register and the ID/EX register. It covers four cases:
//   - load-use hazards
//   - jr/jalr reading a register that is still being produced in EX
//   - taken branches resolved in EX
//   - jumps decoded in ID
// A two-state FSM supplies the second stall cycle of a jr that follows a
// load. Two saturating counters record stall cycles and flush cycles for
// performance debug.
//
// Ports
//   clk, reset        rising-edge clock; asynchronous active-low reset
//   id_rs/id_rt       source registers of the instruction in ID
//   id_uses_rt        ID instruction actually reads Rt
//   id_jump, id_jr    ID instruction is a jump / a register-target jump
//   ex_memrd          EX instruction is a load
//   ex_regwr          EX instruction writes ex_dst
//   ex_dst            final destination register of the EX instruction
//   ex_branch_taken   branch in EX resolved taken this cycle
//   cnt_clr           synchronous clear of both counters
//   pc_stall          hold PC
//   ifid_stall        hold IF/ID (always equal to pc_stall)
//   ifid_flush        zero IF/ID
//   idex_flush        bubble into ID/EX
//   stall_cnt         saturating count of cycles with pc_stall
//   flush_cnt         saturating count of cycles with either flush
//
// State table
//   state    | meaning
//   RUN      | normal operation; hazards resolved combinationally
//   JR_WAIT  | second stall cycle of jr-after-load (load data leaves MEM)

module hazard_ctrl #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic             ex_memrd,
  input  logic             ex_regwr,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_branch_taken,
  input  logic             cnt_clr,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_JR_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic dst_nz;
  logic hz_lu;
  logic hz_jr;
  logic stall_c;
  logic ifid_flush_c;
  logic idex_flush_c;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  always_comb begin
    dst_nz = (ex_dst != '0);
    hz_lu  = ex_memrd & dst_nz &
             ((ex_dst == id_rs) | (id_uses_rt & (ex_dst == id_rt)));
    hz_jr  = id_jr & ex_regwr & dst_nz & (ex_dst == id_rs);
  end

  // Next state and Mealy outputs. Outputs stay 0 while reset is asserted,
  // so they drop at once when reset hits, even mid-JR_WAIT.
  always_comb begin
    state_d      = ST_RUN;
    stall_c      = 1'b0;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;

    if (reset) begin
      if (ex_branch_taken) begin
        // Wrong-path instructions in IF and ID die. A pending jr wait dies with them.
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
      end else if (state_q == ST_JR_WAIT) begin
        stall_c      = 1'b1;
        idex_flush_c = 1'b1;
      end else if (hz_jr && ex_memrd) begin
        // jr reads its target in ID, so it cannot use EX forwarding.
        // Wait until the load data leaves MEM.
        stall_c      = 1'b1;
        idex_flush_c = 1'b1;
        state_d      = ST_JR_WAIT;
      end else if (hz_lu || hz_jr) begin
        stall_c      = 1'b1;
        idex_flush_c = 1'b1;
      end else if (id_jump) begin
        ifid_flush_c = 1'b1;
      end
    end
  end

  // Counters are driven from the same-cycle outputs. Clear wins over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_c && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if ((ifid_flush_c || idex_flush_c) && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_stall   = stall_c;
  assign ifid_stall = stall_c;
  assign ifid_flush = ifid_flush_c;
  assign idex_flush = idex_flush_c;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule
